fizzbuzz_checker: RTL
=====================

FIZZBUZZ_CHECKER -- requirements
Module: fizzbuzz_checker

Interface
REQ-001 SHALL have parameter FIZZ, default 3, fizz period in samples.
REQ-002 SHALL have parameter BUZZ, default 5, buzz period in samples.
REQ-003 SHALL have parameter MAX_CYCLES, default 100, sequence length; index runs 0..MAX_CYCLES-1 then wraps.
REQ-004 SHALL have parameter RESYNC_THRESH, default 3, consecutive mismatches that force loss of lock.
REQ-005 SHALL have parameter CNT_W, default 16, error counter width.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  sample qualifier; fizz/buzz/fizzbuzz sampled only when high.
REQ-009 SHALL have ports fizz, buzz, fizzbuzz  input  1 each  observed stream.
REQ-010 SHALL have port locked  output  1  checker tracking stream.
REQ-011 SHALL have port index  output  IW=max(1,ceil(log2(MAX_CYCLES)))  recovered index of last accepted sample.
REQ-012 SHALL have port mismatch  output  1  one-cycle pulse, last sample differed from expected.
REQ-013 SHALL have port proto_err  output  1  one-cycle pulse, last sample had fizzbuzz != fizz&buzz.
REQ-014 SHALL have port err_count  output  CNT_W  saturating mismatch count.

Function
REQ-015 SHALL implement states IDLE, TRACK, RESYNC; all outputs registered, updated the cycle after a valid sample; no output change on cycles with in_valid low except pulses returning to 0.
REQ-016 Expected for index i SHALL be ef=(i mod FIZZ==0), eb=(i mod BUZZ==0), efb=ef&eb, via running modulo counters cleared when index wraps to 0.
REQ-017 IDLE: valid sample with fizz=buzz=fizzbuzz=1 -> TRACK, index=0, locked=1; any other valid sample -> stay IDLE, mismatch pulse, counted.
REQ-018 TRACK: each valid sample compared to expected at index+1 (wrap MAX_CYCLES-1 -> 0); index advances regardless of match.
REQ-019 TRACK mismatch SHALL pulse mismatch, increment err_count and consecutive-miss counter; a match clears the consecutive-miss counter.
REQ-020 Consecutive misses reaching RESYNC_THRESH SHALL enter RESYNC, drop locked in same update, clear miss counter.
REQ-021 RESYNC: valid sample with fizzbuzz=1 (and fizz=buzz=1) -> TRACK, index=0, locked=1; other samples ignored, not counted.
REQ-022 proto_err SHALL pulse in every state on valid sample with fizzbuzz != (fizz&buzz); such a sample also counts as mismatch in TRACK.
REQ-023 err_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 Expected-index arithmetic SHALL be IW bits; wrap compare against MAX_CYCLES-1 exactly, no out-of-range index ever output.

Reset
REQ-025 reset high at a clock edge SHALL force IDLE, locked=0, index=0, mismatch=0, proto_err=0, err_count=0, miss counter and modulo counters 0, overriding in_valid same cycle.
REQ-026 reset mid-TRACK SHALL discard lock; next valid sample after reset handled per REQ-017.

Configuration
REQ-027 Macro FIZZBUZZ_CHECKER_ERRCNT_EN defined: err_count register and saturating increment present per REQ-019/023.
REQ-028 Macro undefined: no counter register; err_count tied to 0; all other behaviour unchanged.

Verification
REQ-029 Defaults, reset then 100 valid samples from conforming generator (index 0 = all ones) -> locked=1 from first update, index 0..99, mismatch never pulses, err_count=0.
REQ-030 Conforming stream of 250 samples with in_valid low every 3rd cycle -> index wraps 99->0 twice, no mismatch, index frozen on invalid cycles.
REQ-031 Locked at index 9, corrupt sample 10 (buzz=0) -> single mismatch pulse, err_count=1, locked stays 1, index=10.
REQ-032 Locked, three consecutive corrupted samples -> err_count=3, locked=0 after third; later fizzbuzz sample -> locked=1, index=0.
REQ-033 Sample fizz=0,buzz=0,fizzbuzz=1 in TRACK -> proto_err and mismatch pulse same cycle, err_count+1.
REQ-034 ERRCNT_EN with CNT_W=2, five mismatches -> err_count=3 held; without macro err_count=0 throughout.

Source files
------------

// File: rtl/fizzbuzz_checker.sv
// FizzBuzz stream checker: locks on an all-ones sample, then tracks the expected
// fizz/buzz/fizzbuzz pattern. Define FIZZBUZZ_CHECKER_ERRCNT_EN to build the error counter.
module fizzbuzz_checker #(
  parameter int FIZZ          = 3,
  parameter int BUZZ          = 5,
  parameter int MAX_CYCLES    = 100,
  parameter int RESYNC_THRESH = 3,
  parameter int CNT_W         = 16,
  localparam int IW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             fizz,
  input  logic             buzz,
  input  logic             fizzbuzz,
  output logic             locked,
  output logic [IW-1:0]    index,
  output logic             mismatch,
  output logic             proto_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = (FIZZ > 1) ? $clog2(FIZZ) : 1;
  localparam int BW = (BUZZ > 1) ? $clog2(BUZZ) : 1;
  localparam int MW = (RESYNC_THRESH > 0) ? $clog2(RESYNC_THRESH + 1) : 1;

  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nx;
  logic [FW-1:0]   fm_q, fm_d, fm_nx;
  logic [BW-1:0]   bm_q, bm_d, bm_nx;
  logic [MW-1:0]   miss_q, miss_d;
  logic            locked_q, locked_d;
  logic            mism_q, mism_d;
  logic            proto_q, proto_d;
  logic            count_inc;
  logic [2:0]      obs, exp_vec;
  logic            all_ones;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fm_d      = fm_q;
    bm_d      = bm_q;
    miss_d    = miss_q;
    locked_d  = locked_q;
    mism_d    = 1'b0;
    proto_d   = 1'b0;
    count_inc = 1'b0;

    // Modulo counters follow the index and restart whenever it wraps to 0.
    idx_nx  = (idx_q == IW'(MAX_CYCLES - 1)) ? '0 : idx_q + 1'b1;
    fm_nx   = (idx_nx == '0 || fm_q == FW'(FIZZ - 1)) ? '0 : fm_q + 1'b1;
    bm_nx   = (idx_nx == '0 || bm_q == BW'(BUZZ - 1)) ? '0 : bm_q + 1'b1;
    exp_vec = {fm_nx == '0, bm_nx == '0, (fm_nx == '0) && (bm_nx == '0)};
    obs      = {fizz, buzz, fizzbuzz};
    all_ones = &obs;

    if (in_valid) begin
      proto_d = fizzbuzz != (fizz & buzz);
      unique case (state_q)
        IDLE: begin
          if (all_ones) begin
            state_d  = TRACK;
            idx_d    = '0;
            fm_d     = '0;
            bm_d     = '0;
            miss_d   = '0;
            locked_d = 1'b1;
          end else begin
            mism_d    = 1'b1;
            count_inc = 1'b1;
          end
        end
        TRACK: begin
          idx_d = idx_nx;
          fm_d  = fm_nx;
          bm_d  = bm_nx;
          if (obs != exp_vec) begin
            mism_d    = 1'b1;
            count_inc = 1'b1;
            if (miss_q >= MW'(RESYNC_THRESH - 1)) begin
              state_d  = RESYNC;
              locked_d = 1'b0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        RESYNC: begin
          if (all_ones) begin
            state_d  = TRACK;
            idx_d    = '0;
            fm_d     = '0;
            bm_d     = '0;
            miss_d   = '0;
            locked_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      fm_q     <= '0;
      bm_q     <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      mism_q   <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fm_q     <= fm_d;
      bm_q     <= bm_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      mism_q   <= mism_d;
      proto_q  <= proto_d;
    end
  end

`ifdef FIZZBUZZ_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (count_inc && err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_count_inc;
  assign unused_count_inc = count_inc;
  assign err_count        = '0;
`endif

  assign locked    = locked_q;
  assign index     = idx_q;
  assign mismatch  = mism_q;
  assign proto_err = proto_q;

endmodule
